// File: rtl/hazard_fwd_scoreboard.sv
// Hazard detection and forwarding control for the pipelined core.
// A shift-register scoreboard follows each instruction's destination from
// EX (stage 1) to WB (stage DEPTH). The block stalls ID on RAW hazards that
// forwarding cannot yet cover (including load latency), and it drives per-operand
// forwarding selects for the EX operand muxes.
// DEPTH must be at least 2 + LOAD_LAT. If it is not, a load result could leave
// the scoreboard before it is ready to forward.
module hazard_fwd_scoreboard #(
    parameter int NUM_RS     = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_LAT   = 1,
    parameter int REG_ADDR_W = 5,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           arst,
    input  logic                           en,
    input  logic                           issue_valid,
    input  logic [REG_ADDR_W-1:0]          issue_rd,
    input  logic                           issue_wen,
    input  logic                           issue_load,
    input  logic [NUM_RS*REG_ADDR_W-1:0]   issue_rs,
    input  logic [NUM_RS-1:0]              issue_rs_used,
    input  logic                           flush,
    output logic                           stall,
    output logic [NUM_RS*SEL_W-1:0]        fwd_sel,
    output logic                           ex_valid,
    output logic [31:0]                    stall_count
);

    // Stage at which a load result becomes forwardable; ALU results are ready at 2.
    localparam int LOAD_READY = 2 + LOAD_LAT;

    logic [DEPTH:1]                 valid_q, valid_d;
    logic [DEPTH:1]                 wen_q, wen_d;
    logic [DEPTH:1]                 load_q, load_d;
    logic [REG_ADDR_W-1:0]          rd_q [1:DEPTH];
    logic [REG_ADDR_W-1:0]          rd_d [1:DEPTH];
    logic [NUM_RS*REG_ADDR_W-1:0]   rs_ex_q, rs_ex_d;
    logic [NUM_RS-1:0]              rs_used_ex_q, rs_used_ex_d;
    logic [31:0]                    stall_count_q, stall_count_d;

    logic [NUM_RS-1:0]              port_stall;
    logic                           capture;

    genvar gi, gk;
    generate
        for (gi = 0; gi < NUM_RS; gi++) begin : g_port
            logic [REG_ADDR_W-1:0] id_addr;
            logic [REG_ADDR_W-1:0] ex_addr;
            logic [DEPTH:1]        id_match;
            logic [DEPTH:1]        ex_match;
            logic                  hit_stall;
            logic [SEL_W-1:0]      sel;

            assign id_addr = issue_rs[gi*REG_ADDR_W +: REG_ADDR_W];
            assign ex_addr = rs_ex_q[gi*REG_ADDR_W +: REG_ADDR_W];

            // x0 is hard-wired zero, so it never matches a producer.
            for (gk = 1; gk <= DEPTH; gk++) begin : g_stage
                assign id_match[gk] = valid_q[gk] & wen_q[gk] &
                                      (rd_q[gk] == id_addr) & (id_addr != '0);
                assign ex_match[gk] = valid_q[gk] & wen_q[gk] &
                                      (rd_q[gk] == ex_addr) & (ex_addr != '0);
            end

            // Youngest matching producer decides the hazard; the scan runs oldest to youngest so the last hit wins.
            always_comb begin
                hit_stall = 1'b0;
                for (int k = DEPTH; k >= 1; k--) begin
                    if (id_match[k]) begin
                        hit_stall = ((k + 1) < (load_q[k] ? LOAD_READY : 2));
                    end
                end
            end

            // Forward from the youngest producer beyond EX; 0 selects the register file.
            always_comb begin
                sel = '0;
                for (int k = DEPTH; k >= 2; k--) begin
                    if (ex_match[k]) begin
                        sel = SEL_W'(k);
                    end
                end
            end

            assign port_stall[gi] = issue_valid & issue_rs_used[gi] & hit_stall;
            assign fwd_sel[gi*SEL_W +: SEL_W] = rs_used_ex_q[gi] ? sel : '0;
        end
    endgenerate

    assign stall       = (|port_stall) & ~flush;
    assign capture     = issue_valid & ~stall & ~flush;
    assign ex_valid    = valid_q[1];
    assign stall_count = stall_count_q;

    // Advance the scoreboard and stall counter when the pipeline is enabled.
    always_comb begin
        valid_d       = valid_q;
        wen_d         = wen_q;
        load_d        = load_q;
        rd_d          = rd_q;
        rs_ex_d       = rs_ex_q;
        rs_used_ex_d  = rs_used_ex_q;
        stall_count_d = stall_count_q;
        if (en) begin
            for (int k = DEPTH; k >= 2; k--) begin
                valid_d[k] = valid_q[k-1];
                wen_d[k]   = wen_q[k-1];
                load_d[k]  = load_q[k-1];
                rd_d[k]    = rd_q[k-1];
            end
            // A stalled or flushed slot enters EX as a bubble.
            valid_d[1]   = capture;
            wen_d[1]     = issue_wen;
            load_d[1]    = issue_load;
            rd_d[1]      = issue_rd;
            rs_ex_d      = issue_rs;
            rs_used_ex_d = capture ? issue_rs_used : '0;
            if (stall && (stall_count_q != 32'hFFFF_FFFF)) begin
                stall_count_d = stall_count_q + 32'd1;
            end
        end
    end

    // State registers with asynchronous clear of all in-flight entries.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            valid_q       <= '0;
            wen_q         <= '0;
            load_q        <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                rd_q[k] <= '0;
            end
            rs_ex_q       <= '0;
            rs_used_ex_q  <= '0;
            stall_count_q <= '0;
        end else begin
            valid_q       <= valid_d;
            wen_q         <= wen_d;
            load_q        <= load_d;
            rd_q          <= rd_d;
            rs_ex_q       <= rs_ex_d;
            rs_used_ex_q  <= rs_used_ex_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
// Scoreboard bench for hazard_fwd_scoreboard. Two instances are used:
// A = (NUM_RS 2, DEPTH 3, LOAD_LAT 1) and B = (NUM_RS 3, DEPTH 4, LOAD_LAT 2).
// Both instances share the stimulus. Each vector names the instance it checks.
// The driver pushes hand-computed expectations. A monitor on the falling edge
// pops each expectation and compares it against the DUT outputs.
module tb_hazard_fwd_scoreboard;

    logic        clk = 1'b0;
    logic        arst;
    logic        en;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_wen;
    logic        issue_load;
    logic [14:0] issue_rs;
    logic [2:0]  issue_rs_used;
    logic        flush;

    logic        stall_a, ex_valid_a;
    logic [3:0]  fwd_sel_a;
    logic [31:0] stall_count_a;
    logic        stall_b, ex_valid_b;
    logic [8:0]  fwd_sel_b;
    logic [31:0] stall_count_b;

    always #5 clk = ~clk;

    hazard_fwd_scoreboard #(.NUM_RS(2), .DEPTH(3), .LOAD_LAT(1), .REG_ADDR_W(5)) dut_a (
        .clk          (clk),
        .arst         (arst),
        .en           (en),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_wen    (issue_wen),
        .issue_load   (issue_load),
        .issue_rs     (issue_rs[9:0]),
        .issue_rs_used(issue_rs_used[1:0]),
        .flush        (flush),
        .stall        (stall_a),
        .fwd_sel      (fwd_sel_a),
        .ex_valid     (ex_valid_a),
        .stall_count  (stall_count_a)
    );

    hazard_fwd_scoreboard #(.NUM_RS(3), .DEPTH(4), .LOAD_LAT(2), .REG_ADDR_W(5)) dut_b (
        .clk          (clk),
        .arst         (arst),
        .en           (en),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_wen    (issue_wen),
        .issue_load   (issue_load),
        .issue_rs     (issue_rs),
        .issue_rs_used(issue_rs_used),
        .flush        (flush),
        .stall        (stall_b),
        .fwd_sel      (fwd_sel_b),
        .ex_valid     (ex_valid_b),
        .stall_count  (stall_count_b)
    );

    typedef struct {
        string       name;
        bit          use_b;
        logic        stall;
        logic [8:0]  fwd;
        logic        exv;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Monitor: compare each outstanding expectation away from the rising edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            logic        a_st, a_exv;
            logic [8:0]  a_fwd;
            logic [31:0] a_cnt;
            e = exp_q.pop_front();
            if (e.use_b) begin
                a_st = stall_b; a_fwd = fwd_sel_b; a_exv = ex_valid_b; a_cnt = stall_count_b;
            end else begin
                a_st = stall_a; a_fwd = {5'b0, fwd_sel_a}; a_exv = ex_valid_a; a_cnt = stall_count_a;
            end
            vectors++;
            if (a_st !== e.stall || a_fwd !== e.fwd || a_exv !== e.exv || a_cnt !== e.cnt) begin
                miscompares++;
                $display("FAIL %s: got stall=%0b fwd=%h ex_valid=%0b count=%0d, expected stall=%0b fwd=%h ex_valid=%0b count=%0d",
                         e.name, a_st, a_fwd, a_exv, a_cnt, e.stall, e.fwd, e.exv, e.cnt);
            end else begin
                $display("vec %-14s %s stall=%0b fwd=%h ex_valid=%0b count=%0d",
                         e.name, e.use_b ? "B" : "A", a_st, a_fwd, a_exv, a_cnt);
            end
        end
    end

    // Apply one cycle of stimulus just after the rising edge and queue its expected response.
    task automatic step(input string nm, input bit use_b, input logic rst_v, input logic en_v,
                        input logic vld, input int rd, input logic wen, input logic ld,
                        input int r0, input int r1, input int r2, input logic [2:0] used,
                        input logic fl, input logic e_st, input int f0, input int f1, input int f2,
                        input logic e_exv, input int e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        arst          = rst_v;
        en            = en_v;
        issue_valid   = vld;
        issue_rd      = 5'(rd);
        issue_wen     = wen;
        issue_load    = ld;
        issue_rs      = {5'(r2), 5'(r1), 5'(r0)};
        issue_rs_used = used;
        flush         = fl;
        e.name  = nm;
        e.use_b = use_b;
        e.stall = e_st;
        if (use_b) e.fwd = {3'(f2), 3'(f1), 3'(f0)};
        else       e.fwd = {5'b0, 2'(f1), 2'(f0)};
        e.exv   = e_exv;
        e.cnt   = 32'(e_cnt);
        exp_q.push_back(e);
    endtask

    initial begin
        arst = 1'b1; en = 1'b1; issue_valid = 1'b0; issue_rd = '0; issue_wen = 1'b0;
        issue_load = 1'b0; issue_rs = '0; issue_rs_used = '0; flush = 1'b0;

        //    name            B  rst en  vld rd wen ld  r0 r1 r2 used    fl  st f0 f1 f2 exv cnt
        // Instance A: DEPTH 3, LOAD_LAT 1
        step("rst_a",         0, 1, 1,   0, 0, 0, 0,   0, 0, 0, 3'b000, 0,  0, 0, 0, 0, 0, 0);
        step("alu_x5",        0, 0, 1,   1, 5, 1, 0,   1, 2, 0, 3'b011, 0,  0, 0, 0, 0, 0, 0);
        step("sub_rs5",       0, 0, 1,   1, 8, 1, 0,   5, 3, 0, 3'b011, 0,  0, 0, 0, 0, 1, 0);
        step("fwd_alu",       0, 0, 1,   0, 0, 0, 0,   0, 0, 0, 3'b000, 0,  0, 2, 0, 0, 1, 0);
        step("ld_x6",         0, 0, 1,   1, 6, 1, 1,  10, 0, 0, 3'b001, 0,  0, 0, 0, 0, 0, 0);
        step("ldu_stall",     0, 0, 1,   1, 11,1, 0,   4, 6, 0, 3'b011, 0,  1, 0, 0, 0, 1, 0);
        step("ldu_release",   0, 0, 1,   1, 11,1, 0,   4, 6, 0, 3'b011, 0,  0, 0, 0, 0, 0, 1);
        step("ldu_fwd",       0, 0, 1,   0, 0, 0, 0,   0, 0, 0, 3'b000, 0,  0, 0, 3, 0, 1, 1);
        step("ld_x0",         0, 0, 1,   1, 0, 1, 1,   0, 0, 0, 3'b000, 0,  0, 0, 0, 0, 0, 1);
        step("use_x0",        0, 0, 1,   1, 12,1, 0,   0, 11,0, 3'b001, 0,  0, 0, 0, 0, 1, 1);
        step("ld_x13",        0, 0, 1,   1, 13,1, 1,   0, 0, 0, 3'b000, 0,  0, 0, 0, 0, 1, 1);
        step("unused_rs",     0, 0, 1,   1, 14,1, 0,  13, 13,0, 3'b000, 0,  0, 0, 0, 0, 1, 1);
        step("unused_fwd",    0, 0, 1,   0, 0, 0, 0,   0, 0, 0, 3'b000, 0,  0, 0, 0, 0, 1, 1);
        step("x9_a",          0, 0, 1,   1, 9, 1, 0,   1, 1, 0, 3'b000, 0,  0, 0, 0, 0, 0, 1);
        step("x9_b",          0, 0, 1,   1, 9, 1, 0,   1, 1, 0, 3'b000, 0,  0, 0, 0, 0, 1, 1);
        step("use_x9",        0, 0, 1,   1, 15,1, 0,   9, 9, 0, 3'b011, 0,  0, 0, 0, 0, 1, 1);
        step("fwd_young",     0, 0, 1,   0, 0, 0, 0,   0, 0, 0, 3'b000, 0,  0, 2, 2, 0, 1, 1);
        step("ld_x6b",        0, 0, 1,   1, 6, 1, 1,   0, 0, 0, 3'b000, 0,  0, 0, 0, 0, 0, 1);
        step("flush_ldu",     0, 0, 1,   1, 16,1, 0,   6, 0, 0, 3'b001, 1,  0, 0, 0, 0, 1, 1);
        step("flush_bubble",  0, 0, 1,   0, 0, 0, 0,   0, 0, 0, 3'b000, 0,  0, 0, 0, 0, 0, 1);
        // Instance B: NUM_RS 3, DEPTH 4, LOAD_LAT 2
        step("rst_b",         1, 1, 1,   0, 0, 0, 0,   0, 0, 0, 3'b000, 0,  0, 0, 0, 0, 0, 0);
        step("ld_x7",         1, 0, 1,   1, 7, 1, 1,   0, 0, 0, 3'b000, 0,  0, 0, 0, 0, 0, 0);
        step("l2_stall1",     1, 0, 1,   1, 8, 1, 0,   7, 0, 0, 3'b001, 0,  1, 0, 0, 0, 1, 0);
        step("l2_stall2",     1, 0, 1,   1, 8, 1, 0,   7, 0, 0, 3'b001, 0,  1, 0, 0, 0, 0, 1);
        step("l2_release",    1, 0, 1,   1, 8, 1, 0,   7, 0, 0, 3'b001, 0,  0, 0, 0, 0, 0, 2);
        step("l2_fwd",        1, 0, 1,   0, 0, 0, 0,   0, 0, 0, 3'b000, 0,  0, 4, 0, 0, 1, 2);
        step("ld_x7b",        1, 0, 1,   1, 7, 1, 1,   0, 0, 0, 3'b000, 0,  0, 0, 0, 0, 0, 2);
        step("indep",         1, 0, 1,   1, 20,1, 0,   1, 2, 3, 3'b000, 0,  0, 0, 0, 0, 1, 2);
        step("gap_stall",     1, 0, 1,   1, 21,1, 0,   0, 7, 0, 3'b010, 0,  1, 0, 0, 0, 1, 2);
        step("gap_release",   1, 0, 1,   1, 21,1, 0,   0, 7, 0, 3'b010, 0,  0, 0, 0, 0, 0, 3);
        step("gap_fwd",       1, 0, 1,   0, 0, 0, 0,   0, 0, 0, 3'b000, 0,  0, 0, 4, 0, 1, 3);
        step("ld_x9",         1, 0, 1,   1, 9, 1, 1,   0, 0, 0, 3'b000, 0,  0, 0, 0, 0, 0, 3);
        step("alu_x9",        1, 0, 1,   1, 9, 1, 0,   0, 0, 0, 3'b000, 0,  0, 0, 0, 0, 1, 3);
        step("young_nostall", 1, 0, 1,   1, 22,1, 0,   0, 0, 9, 3'b100, 0,  0, 0, 0, 0, 1, 3);
        step("fwd_port2",     1, 0, 1,   0, 0, 0, 0,   0, 0, 0, 3'b000, 0,  0, 0, 0, 2, 1, 3);
        step("ld_x10",        1, 0, 1,   1, 10,1, 1,   0, 0, 0, 3'b000, 0,  0, 0, 0, 0, 0, 3);
        step("en_stall",      1, 0, 1,   1, 23,1, 0,  10, 0, 0, 3'b001, 0,  1, 0, 0, 0, 1, 3);
        step("en_lo1",        1, 0, 0,   1, 23,1, 0,  10, 0, 0, 3'b001, 0,  1, 0, 0, 0, 0, 4);
        step("en_lo2",        1, 0, 0,   1, 23,1, 0,  10, 0, 0, 3'b001, 0,  1, 0, 0, 0, 0, 4);
        step("arst_mid",      1, 1, 1,   1, 23,1, 0,  10, 0, 0, 3'b001, 0,  0, 0, 0, 0, 0, 0);
        step("post_rst",      1, 0, 1,   1, 23,1, 0,  10, 0, 0, 3'b001, 0,  0, 0, 0, 0, 0, 0);
        step("post_fwd",      1, 0, 1,   0, 0, 0, 0,   0, 0, 0, 3'b000, 0,  0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
